// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared parser state encoding and error-index constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_EMIT = 3'd4
  } state_e;

  localparam int ERR_W       = 5;
  localparam int ERR_CHK     = 0;
  localparam int ERR_LEN     = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_BREAK   = 3;
  localparam int ERR_OVERRUN = 4;

  // Address width for a memory of DEPTH entries, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_buf.sv
// ---------------------------------------------------------------------------
// frame_buf: DEPTH x 8 payload store, one write port, registered read.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser: SOF/LEN/payload/CHK frame parser with streaming output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF            = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_break_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  output logic       err_chk_o,
  output logic       err_len_o,
  output logic       err_timeout_o,
  output logic       err_break_o,
  output logic       err_overrun_o,
  output logic       busy_o
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = addr_width(MAX_LEN);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [TO_W-1:0]    tmo_q, tmo_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               wr_en;
  logic [AW-1:0]      rd_addr;
  logic [7:0]         chk_sum;
  logic               len_ok;
  logic               in_frame;
  logic               tmo_hit;
  logic               is_last;
  logic               xfer;

  assign chk_sum  = sum_q + in_data_i;
  assign len_ok   = (in_data_i != 8'd0) && (in_data_i <= 8'(MAX_LEN));
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign tmo_hit  = in_frame && !in_valid_i && (tmo_q == TO_MAX);
  assign is_last  = (idx_q == (len_q - IDX_W'(1)));
  assign xfer     = (state_q == ST_EMIT) && out_ready_i;

  // Look one entry ahead on a transfer so the registered read lands in time.
  assign rd_addr = !xfer ? idx_q[AW-1:0] :
                   is_last ? '0 : (idx_q[AW-1:0] + AW'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    err_d   = '0;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && !in_break_i && (in_data_i == SOF)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (in_valid_i) begin
          if (in_break_i) begin
            err_d[ERR_BREAK] = 1'b1;
            state_d          = ST_IDLE;
          end else if (len_ok) begin
            len_d   = in_data_i[IDX_W-1:0];
            sum_d   = in_data_i;  // LEN is part of the checksum
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            err_d[ERR_LEN] = 1'b1;
            state_d        = ST_IDLE;
          end
        end else if (tmo_hit) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (in_valid_i) begin
          if (in_break_i) begin
            err_d[ERR_BREAK] = 1'b1;
            state_d          = ST_IDLE;
          end else begin
            wr_en = 1'b1;
            sum_d = chk_sum;
            if (is_last) begin
              idx_d   = '0;
              state_d = ST_CHK;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else if (tmo_hit) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_IDLE;
        end
      end

      ST_CHK: begin
        if (in_valid_i) begin
          if (in_break_i) begin
            err_d[ERR_BREAK] = 1'b1;
            state_d          = ST_IDLE;
          end else if (chk_sum == 8'd0) begin
            state_d = ST_EMIT;
          end else begin
            err_d[ERR_CHK] = 1'b1;
            state_d        = ST_IDLE;
          end
        end else if (tmo_hit) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_IDLE;
        end
      end

      ST_EMIT: begin
        if (in_valid_i) begin
          err_d[ERR_OVERRUN] = 1'b1;
        end
        if (xfer) begin
          if (is_last) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) begin
      idx_d = '0;
    end
  end

  always_comb begin
    tmo_d = '0;
    if (in_frame && !in_valid_i && (state_d == state_q)) begin
      tmo_d = tmo_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= 8'h00;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_frame_buf (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q[AW-1:0]),
    .wr_data_i (in_data_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (out_data_o)
  );

  assign out_valid_o   = (state_q == ST_EMIT);
  assign out_last_o    = (state_q == ST_EMIT) && is_last;
  assign busy_o        = (state_q != ST_IDLE);
  assign err_chk_o     = err_q[ERR_CHK];
  assign err_len_o     = err_q[ERR_LEN];
  assign err_timeout_o = err_q[ERR_TIMEOUT];
  assign err_break_o   = err_q[ERR_BREAK];
  assign err_overrun_o = err_q[ERR_OVERRUN];

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser: directed self-checking bench for uart_frame_parser.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_frame_parser;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_break;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       err_chk, err_len, err_timeout, err_break, err_overrun;
  logic       busy;
  logic [4:0] errs;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  uart_frame_parser #(
    .SOF            (8'hA5),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_break_i    (in_break),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_last_o    (out_last),
    .err_chk_o     (err_chk),
    .err_len_o     (err_len),
    .err_timeout_o (err_timeout),
    .err_break_o   (err_break),
    .err_overrun_o (err_overrun),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // {overrun, break, timeout, len, chk}
  assign errs = {err_overrun, err_break, err_timeout, err_len, err_chk};

  always @(posedge clk) begin
    if (out_valid && out_ready) n_xfer <= n_xfer + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is taken on the following rising edge.
  task automatic send(input logic [7:0] d, input logic brk);
    in_valid = 1'b1;
    in_data  = d;
    in_break = brk;
    @(negedge clk);
    in_valid = 1'b0;
    in_break = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic last);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data), 32'(d));
    check({tag, "_last"},  32'(out_last), 32'(last));
    check({tag, "_errs"},  32'(errs), 32'd0);
  endtask

  initial begin
    int x0;
    logic [7:0] b;
    logic [7:0] s;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_break  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_errs",  32'(errs),      32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic frame, consecutive output with out_ready held high
    x0 = n_xfer;
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h97, 0);
    expect_out("f1_b0", 8'h11, 1'b0);
    @(negedge clk);
    expect_out("f1_b1", 8'h22, 1'b0);
    @(negedge clk);
    expect_out("f1_b2", 8'h33, 1'b1);
    @(negedge clk);
    check("f1_done_valid", 32'(out_valid), 32'd0);
    check("f1_done_busy",  32'(busy),      32'd0);
    check("f1_xfers",      32'(n_xfer - x0), 32'd3);

    // Checksum failure
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h98, 0);
    check("chk_errs",  32'(errs),      32'b00001);
    check("chk_valid", 32'(out_valid), 32'd0);
    check("chk_busy",  32'(busy),      32'd0);
    @(negedge clk);
    check("chk_pulse_end", 32'(errs),  32'd0);
    check("chk_no_out",    32'(out_valid), 32'd0);

    // Length out of range: zero and MAX_LEN+1
    send(8'hA5, 0); send(8'h00, 0);
    check("len0_errs", 32'(errs), 32'b00010);
    check("len0_busy", 32'(busy), 32'd0);
    send(8'hA5, 0); send(8'h11, 0);
    check("len17_errs",  32'(errs),      32'b00010);
    check("len17_busy",  32'(busy),      32'd0);
    check("len17_valid", 32'(out_valid), 32'd0);

    // Timeout exactly TMO idle cycles after the last byte
    send(8'hA5, 0); send(8'h02, 0); send(8'h44, 0);
    check("tmo_busy0", 32'(busy), 32'd1);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_early_errs", 32'(errs), 32'd0);
    check("tmo_early_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_errs", 32'(errs), 32'b00100);
    check("tmo_busy", 32'(busy), 32'd0);
    send(8'hA5, 0); send(8'h01, 0); send(8'h7F, 0); send(8'h80, 0);
    expect_out("tmo_next", 8'h7F, 1'b1);
    @(negedge clk);
    check("tmo_next_done", 32'(out_valid), 32'd0);

    // Full MAX_LEN payload
    x0 = n_xfer;
    s  = 8'h10;
    send(8'hA5, 0); send(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 7 + 3);
      s = s + b;
      send(b, 0);
    end
    send(8'(8'h00 - s), 0);
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("max_b%0d", i), 8'(i * 7 + 3), (i == 15));
      @(negedge clk);
    end
    check("max_done",  32'(out_valid),   32'd0);
    check("max_xfers", 32'(n_xfer - x0), 32'd16);

    // Backpressure 1-0-0-1 with an overrun byte injected during EMIT
    x0 = n_xfer;
    send(8'hA5, 0); send(8'h03, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    send(8'hF7, 0);
    expect_out("bp_c0", 8'h01, 1'b0);
    @(negedge clk);
    expect_out("bp_c1", 8'h02, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_c2_valid", 32'(out_valid), 32'd1);
    check("bp_c2_data",  32'(out_data),  32'h02);
    check("bp_c2_last",  32'(out_last),  32'd0);
    check("bp_c2_errs",  32'(errs),      32'b10000);
    check("bp_c2_busy",  32'(busy),      32'd1);
    @(negedge clk);
    expect_out("bp_c3", 8'h02, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    expect_out("bp_c4", 8'h03, 1'b1);
    @(negedge clk);
    check("bp_done",  32'(out_valid),   32'd0);
    check("bp_xfers", 32'(n_xfer - x0), 32'd3);

    // Break mid-frame aborts; break in IDLE is ignored
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 1);
    check("brk_errs",  32'(errs),      32'b01000);
    check("brk_busy",  32'(busy),      32'd0);
    check("brk_valid", 32'(out_valid), 32'd0);
    send(8'hA5, 1);
    check("brk_idle_errs", 32'(errs), 32'd0);
    check("brk_idle_busy", 32'(busy), 32'd0);

    // Reset during EMIT abandons the frame
    out_ready = 1'b0;
    send(8'hA5, 0); send(8'h01, 0); send(8'h7F, 0); send(8'h80, 0);
    expect_out("rst_emit", 8'h7F, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_emit_valid", 32'(out_valid), 32'd0);
    check("rst_emit_busy",  32'(busy),      32'd0);
    check("rst_emit_data",  32'(out_data),  32'h00);
    check("rst_emit_errs",  32'(errs),      32'd0);
    resetn    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(8'hA5, 0); send(8'h01, 0); send(8'hAA, 0); send(8'h55, 0);
    expect_out("post_rst", 8'hAA, 1'b1);
    @(negedge clk);
    check("post_rst_done", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
